bifrost_irqctl: RTL and testbench

// - Parametrised interrupt controller for BIFRÖST; replaces the fixed AND of active-low IRQ lines feeding 6502 IRQB.
// - Per channel: 2-flop sync, polarity, level/edge mode, pending latch, mask. Outputs registered active-low irq_n.
// - CPU sees a register window (status/pending/mask/mode/polarity/vector) through the BIFRÖST register decode.

---
 rtl/bifrost_irqctl_pkg.sv | 13 +
 rtl/bifrost_irqctl_if.sv | 10 +
 rtl/bifrost_irqctl_sync.sv | 22 ++
 rtl/bifrost_irqctl.sv | 100 ++++++++++
 tb/tb_bifrost_irqctl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bifrost_irqctl_pkg.sv
// Shared constants for the BIFROST interrupt controller: register map and reset values.
package bifrost_irqctl_pkg;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_PENDING  = 3'd1;
  localparam logic [2:0] REG_MASK     = 3'd2;
  localparam logic [2:0] REG_MODE     = 3'd3;
  localparam logic [2:0] REG_POLARITY = 3'd4;
  localparam logic [2:0] REG_VECTOR   = 3'd5;
  localparam logic [2:0] REG_NMISEL   = 3'd6;

  localparam logic [7:0] VECTOR_NONE    = 8'h80;
  localparam logic [7:0] POLARITY_RESET = 8'hFF;
endpackage

// File: rtl/bifrost_irqctl_if.sv
// CPU register-window bus into the interrupt controller (decode-qualified write strobe, async read).
interface bifrost_irqctl_if;
  logic       wr_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output wr_en, addr, wdata, input rdata);
  modport slave  (input wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/bifrost_irqctl_sync.sv
// Width-parametrised 2-flop synchronizer with a configurable reset level.
module bifrost_irqctl_sync #(
  parameter int WIDTH   = 8,
  parameter bit RST_VAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/bifrost_irqctl.sv
// BIFROST interrupt controller: per-channel sync/polarity/level-edge pending/mask -> irq_n.
// Optional NMI routing via register 6 when BIFROST_IRQ_NMI_EN is defined.
module bifrost_irqctl
  import bifrost_irqctl_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] irq_in,
  bifrost_irqctl_if.slave     bus,
  output logic                irq_n,
  output logic                nmirq_n
);
  // Bits at and above CHANNELS are unimplemented: read 0, never set.
  localparam logic [8:0] CH_ONES = (9'd1 << CHANNELS) - 9'd1;
  localparam logic [7:0] CH_MASK = CH_ONES[7:0];

  logic [CHANNELS-1:0] sync;
  logic [7:0] active, prev, pending, pend_nxt, mask, mode, polarity, nmisel;
  logic [7:0] set, clr, irq_req;

  function automatic logic [7:0] prio_vec(input logic [7:0] req);
    prio_vec = VECTOR_NONE;
    for (int i = 7; i >= 0; i--)
      if (req[i]) prio_vec = {5'b0, 3'(i)};
  endfunction

  generate
    if (SYNC_EN) begin : g_sync
      bifrost_irqctl_sync #(.WIDTH(CHANNELS), .RST_VAL(1'b1)) u_sync (
        .clock(clock), .reset_n(reset_n), .d(irq_in), .q(sync));
    end else begin : g_nosync
      assign sync = irq_in;
    end
  endgenerate

  assign active  = (8'(sync) ^ polarity) & CH_MASK;
  assign set     = active & ~prev;
  assign clr     = (bus.wr_en && bus.addr == REG_PENDING) ? bus.wdata : 8'h00;
  assign irq_req = pending & mask & ~nmisel;

  // Edge channels: set beats a same-cycle clear. Level channels track the input.
  always_comb begin
    pend_nxt = ((mode & (set | (pending & ~clr))) | (~mode & active)) & CH_MASK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= 8'h00;
      pending  <= 8'h00;
      mask     <= 8'h00;
      mode     <= 8'h00;
      polarity <= POLARITY_RESET & CH_MASK;
      irq_n    <= 1'b1;
    end else begin
      prev    <= active;
      pending <= pend_nxt;
      irq_n   <= ~|irq_req;
      if (bus.wr_en) begin
        case (bus.addr)
          REG_MASK:     mask     <= bus.wdata & CH_MASK;
          REG_MODE:     mode     <= bus.wdata & CH_MASK;
          REG_POLARITY: polarity <= bus.wdata & CH_MASK;
          default: ;
        endcase
      end
    end
  end

`ifdef BIFROST_IRQ_NMI_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nmisel  <= 8'h00;
      nmirq_n <= 1'b1;
    end else begin
      nmirq_n <= ~|(pending & mask & nmisel);
      if (bus.wr_en && bus.addr == REG_NMISEL) nmisel <= bus.wdata & CH_MASK;
    end
  end
`else
  assign nmisel  = 8'h00;
  assign nmirq_n = 1'b1;
`endif

  always_comb begin
    bus.rdata = 8'h00;
    case (bus.addr)
      REG_STATUS:   bus.rdata = active;
      REG_PENDING:  bus.rdata = pending;
      REG_MASK:     bus.rdata = mask;
      REG_MODE:     bus.rdata = mode;
      REG_POLARITY: bus.rdata = polarity;
      REG_VECTOR:   bus.rdata = prio_vec(irq_req);
      REG_NMISEL:   bus.rdata = nmisel;
      default:      bus.rdata = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_bifrost_irqctl.sv
// Scoreboard bench for bifrost_irqctl: expected values queued with stimulus, popped on observation.
module tb_bifrost_irqctl;
  import bifrost_irqctl_pkg::*;

  logic       clock, reset_n;
  logic [7:0] irq_in;
  logic       irq_n, nmirq_n;
  int         n_chk = 0, n_pass = 0;

  typedef struct { string tag; logic [7:0] val; } exp_t;
  exp_t sb[$];

  bifrost_irqctl_if bus ();

  bifrost_irqctl #(.CHANNELS(8), .SYNC_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .bus(bus),
    .irq_n(irq_n), .nmirq_n(nmirq_n));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 8'h%02h, want 8'h%02h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_underflow: got 8'h%02h, want none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] e);
    push(tag, e);
    bus.addr = a;
    #1;
    observe(bus.rdata);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push(tag, {7'b0, e});
    observe({7'b0, irq_n});
  endtask

  task automatic chk_nmi(input string tag, input logic e);
    push(tag, {7'b0, e});
    observe({7'b0, nmirq_n});
  endtask

  // Strobe held across exactly one posedge; returns on the following negedge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    irq_in = 8'hFF; reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.addr = 3'd0; bus.wdata = 8'h00;

    // Reset: input activity and a write strobe must leave everything at reset values
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      irq_in = ~irq_in;
      bus.wr_en = 1'b1; bus.addr = REG_MASK; bus.wdata = 8'hFF;
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
    chk_irq("rst_irq_n", 1'b1);
    chk_nmi("rst_nmirq_n", 1'b1);
    rd("rst_polarity", REG_POLARITY, 8'hFF);
    rd("rst_mask", REG_MASK, 8'h00);
    rd("rst_vector", REG_VECTOR, 8'h80);
    rd("rst_pending", REG_PENDING, 8'h00);
    irq_in = 8'hFF;
    cyc(1);
    reset_n = 1'b1;
    cyc(3);
    rd("post_rst_pending", REG_PENDING, 8'h00);

    // Level mode: 4-clock latency both ways
    wr(REG_MASK, 8'h04);
    irq_in[2] = 1'b0;
    cyc(3);
    chk_irq("lvl_assert_3clk", 1'b1);
    cyc(1);
    chk_irq("lvl_assert_4clk", 1'b0);
    rd("lvl_vector", REG_VECTOR, 8'h02);
    rd("lvl_status", REG_STATUS, 8'h04);
    irq_in[2] = 1'b1;
    cyc(3);
    chk_irq("lvl_release_3clk", 1'b0);
    cyc(1);
    chk_irq("lvl_release_4clk", 1'b1);

    // Edge mode + write-1-to-clear
    wr(REG_MASK, 8'h01);
    wr(REG_MODE, 8'h01);
    irq_in[0] = 1'b0;
    cyc(3);
    irq_in[0] = 1'b1;
    cyc(6);
    rd("edge_pending_held", REG_PENDING, 8'h01);
    chk_irq("edge_irq_low", 1'b0);
    wr(REG_PENDING, 8'h01);
    rd("w1c_pending", REG_PENDING, 8'h00);
    chk_irq("w1c_irq_lag", 1'b0);
    cyc(1);
    chk_irq("w1c_irq_high", 1'b1);

    // Set beats clear on ch1
    wr(REG_MODE, 8'h03);
    wr(REG_MASK, 8'h02);
    irq_in[1] = 1'b0;
    cyc(5);
    rd("sbc_first_edge", REG_PENDING, 8'h02);
    irq_in[1] = 1'b1;
    cyc(5);
    irq_in[1] = 1'b0;
    cyc(2);
    wr(REG_PENDING, 8'h02);   // strobe lands on the edge-detect clock
    rd("sbc_set_wins", REG_PENDING, 8'h02);
    cyc(2);
    chk_irq("sbc_irq_low", 1'b0);
    irq_in[1] = 1'b1;
    cyc(4);
    wr(REG_PENDING, 8'h02);
    rd("sbc_plain_clear", REG_PENDING, 8'h00);

    // Priority and mask, level mode
    wr(REG_MODE, 8'h00);
    irq_in = 8'hD7;
    cyc(5);
    rd("prio_pending", REG_PENDING, 8'h28);
    wr(REG_PENDING, 8'h28);
    rd("lvl_w1c_no_effect", REG_PENDING, 8'h28);
    wr(REG_MASK, 8'h28);
    rd("prio_vec_3", REG_VECTOR, 8'h03);
    wr(REG_VECTOR, 8'h11);
    rd("vector_ro", REG_VECTOR, 8'h03);
    wr(REG_MASK, 8'h20);
    rd("prio_vec_5", REG_VECTOR, 8'h05);
    chk_irq("prio_irq_low", 1'b0);
    wr(REG_MASK, 8'h00);
    rd("prio_vec_none", REG_VECTOR, 8'h80);
    chk_irq("mask_lag", 1'b0);
    cyc(1);
    chk_irq("mask_off_irq_high", 1'b1);
    rd("reg7_zero", 3'd7, 8'h00);
    irq_in = 8'hFF;
    cyc(5);

    // NMI routing
    wr(REG_NMISEL, 8'h02);
    wr(REG_MODE, 8'h02);
    wr(REG_MASK, 8'h02);
    irq_in[1] = 1'b0;
    cyc(5);
`ifdef BIFROST_IRQ_NMI_EN
    chk_nmi("nmi_low", 1'b0);
    chk_irq("nmi_irq_stays_high", 1'b1);
    rd("nmi_vector_excluded", REG_VECTOR, 8'h80);
    rd("nmisel_rw", REG_NMISEL, 8'h02);
`else
    chk_nmi("nmi_tied_high", 1'b1);
    chk_irq("nmi_off_irq_low", 1'b0);
    rd("nmisel_reads_zero", REG_NMISEL, 8'h00);
    rd("nmi_off_vector", REG_VECTOR, 8'h01);
`endif

    // Asynchronous reset forces the outputs high between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk_irq("async_rst_irq", 1'b1);
    chk_nmi("async_rst_nmi", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
